// File: rtl/mcdiv2o.sv
// Multi-cycle signed/unsigned integer divider: two restoring-subtract steps per
// clock, quotient and remainder registered at the end of the n/2 iterations.
module mcdiv2o #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sign,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quot,
    output logic [n-1:0] rem,
    output logic         div0
);

    localparam int ITERS = n / 2;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_a_q, neg_a_d;
    logic          neg_b_q, neg_b_d;
    logic          bz_q, bz_d;
    logic [n-1:0]  a_orig_q, a_orig_d;
    logic [n-1:0]  bmag_q, bmag_d;
    logic [n-1:0]  dvd_q, dvd_d;
    logic [n-1:0]  pr_q, pr_d;
    logic [n-1:0]  quot_q, quot_d;
    logic [n-1:0]  rem_q, rem_d;
    logic          div0_q, div0_d;

    logic          neg_a_in, neg_b_in;
    logic [n-1:0]  a_mag, b_mag;
    logic [n:0]    t1, t2;
    logic          ge1, ge2;
    logic [n-1:0]  r1, r2;
    logic [n-1:0]  qmag;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        bz_d     = bz_q;
        a_orig_d = a_orig_q;
        bmag_d   = bmag_q;
        dvd_d    = dvd_q;
        pr_d     = pr_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        div0_d   = div0_q;

        neg_a_in = sign & a[n-1];
        neg_b_in = sign & b[n-1];
        a_mag    = neg_a_in ? -a : a;
        b_mag    = neg_b_in ? -b : b;

        // The trial value is n+1 bits wide; after a successful subtract the
        // result is below |b| and always fits back into n bits.
        t1   = {pr_q, dvd_q[n-1]};
        ge1  = t1 >= {1'b0, bmag_q};
        r1   = ge1 ? (t1[n-1:0] - bmag_q) : t1[n-1:0];
        t2   = {r1, dvd_q[n-2]};
        ge2  = t2 >= {1'b0, bmag_q};
        r2   = ge2 ? (t2[n-1:0] - bmag_q) : t2[n-1:0];
        // Dividend bits leave at the top while quotient bits enter at the bottom.
        qmag = {dvd_q[n-3:0], ge1, ge2};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = ITER;
                    cnt_d    = '0;
                    neg_a_d  = neg_a_in;
                    neg_b_d  = neg_b_in;
                    bz_d     = (b == '0);
                    a_orig_d = a;
                    bmag_d   = b_mag;
                    dvd_d    = a_mag;
                    pr_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                dvd_d = qmag;
                pr_d  = r2;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    if (bz_q) begin
                        quot_d = '1;
                        rem_d  = a_orig_q;
                        div0_d = 1'b1;
                    end else begin
                        quot_d = (neg_a_q ^ neg_b_q) ? -qmag : qmag;
                        rem_d  = neg_a_q ? -r2 : r2;
                        div0_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            bz_q     <= 1'b0;
            a_orig_q <= '0;
            bmag_q   <= '0;
            dvd_q    <= '0;
            pr_q     <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            bz_q     <= bz_d;
            a_orig_q <= a_orig_d;
            bmag_q   <= bmag_d;
            dvd_q    <= dvd_d;
            pr_q     <= pr_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            div0_q   <= div0_d;
        end
    end

    assign busy = (state_q == ITER);
    assign done = (state_q == DONE);
    assign quot = quot_q;
    assign rem  = rem_q;
    assign div0 = div0_q;

endmodule
